// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scanner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the active-low segment patterns ({g,f,e,d,c,b,a}), the special digit
// codes, the scan state encoding, the shadow register layout and a small
// helper that turns a scan index into an active-low anode select.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Shadow copy of one captured display frame. Index 3 = thousands, 0 = units.
  typedef struct packed {
    logic [3:0][3:0] dig;
    logic [3:0]      dp;
  } shadow_t;

  // Special input codes.
  localparam bcd_t CODE_ZERO  = 4'h0;
  localparam bcd_t CODE_MINUS = 4'hA;
  localparam bcd_t CODE_BLANK = 4'hF;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_MINUS = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_E     = 7'b0000110;

  // Scan state encoding: the state value is also the digit position index.
  localparam logic [1:0] SCAN_S0 = 2'd0;  // units
  localparam logic [1:0] SCAN_S1 = 2'd1;  // tens
  localparam logic [1:0] SCAN_S2 = 2'd2;  // hundreds
  localparam logic [1:0] SCAN_S3 = 2'd3;  // thousands

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Next scan state: units -> tens -> hundreds -> thousands -> units.
  function automatic logic [1:0] scan_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      SCAN_S0: n = SCAN_S1;
      SCAN_S1: n = SCAN_S2;
      SCAN_S2: n = SCAN_S3;
      default: n = SCAN_S0;
    endcase
    return n;
  endfunction

  // Active-low one-hot anode select for a scan state.
  function automatic logic [3:0] an_select(input logic [1:0] s);
    logic [3:0] onehot;
    onehot = 4'b0001 << s;
    return ~onehot;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Code-to-segment decoder: 4-bit digit code in, active-low 7-segment pattern out.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
//
// Ports:
//   code : 4-bit code (0-9 digits, A minus, B-E error glyph, F blank)
//   pat  : active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_E;  // 0xB-0xE all show 'E'
    case (code)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_MINUS;
      4'hF: pat = SEG_BLANK;
      default: pat = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed seven-segment driver with leading-zero blanking.
// Latency: an/seg/dp registered, one clock after scan index or shadow change.
// Backpressure: none; load is a one-cycle strobe always accepted.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   load     : capture strobe for dig1000..dig1 and dp_mask
//   dig1000, dig100, dig10, dig1 : BCD/code digits, thousands..units
//   dp_mask  : decimal point enable per position, bit3 = thousands
//   an       : active-low anode selects, bit3 = thousands
//   seg      : active-low segments {g,f,e,d,c,b,a}
//   dp       : active-low decimal point
//   busy     : registered copy of load (one cycle high per capture)
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] dig1000,
  input  logic [3:0] dig100,
  input  logic [3:0] dig10,
  input  logic [3:0] dig1,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    scan_idx;
  shadow_t       sh;

  // ---------------------------------------------------------------------------
  // Prescaler and scan index. Load never touches either, so the display
  // cadence is independent of when new values arrive.
  // ---------------------------------------------------------------------------
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      scan_idx <= SCAN_S0;
    end else begin
      if (tick) begin
        cnt      <= '0;
        scan_idx <= scan_next(scan_idx);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow registers. Inputs are only sampled on load, so the digit bus may
  // carry anything in between. Reset leaves every position showing blank.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh.dig <= {4{CODE_BLANK}};
      sh.dp  <= '0;
      busy   <= 1'b0;
    end else begin
      busy <= load;
      if (load) begin
        sh.dig <= {dig1000, dig100, dig10, dig1};
        sh.dp  <= dp_mask;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking.
  //   clear_above[k] : every position above k holds 0 or the blank code
  //   dp_guard[k]    : a decimal point is lit at k or anywhere above it; a
  //                    zero next to a visible point (e.g. "0.5") must show
  // Units are never blanked so a value of zero still reads "0".
  // ---------------------------------------------------------------------------
  logic [3:0] zero_or_blank;
  logic [3:0] clear_above;
  logic [3:0] dp_guard;
  logic [3:0] blank_pos;

  always_comb begin
    zero_or_blank = '0;
    clear_above   = '0;
    dp_guard      = '0;
    blank_pos     = '0;

    for (int k = 0; k < 4; k++) begin
      zero_or_blank[k] = (sh.dig[k] == CODE_ZERO) || (sh.dig[k] == CODE_BLANK);
    end

    clear_above[3] = 1'b1;
    dp_guard[3]    = sh.dp[3];
    for (int k = 2; k >= 0; k--) begin
      clear_above[k] = clear_above[k+1] & zero_or_blank[k+1];
      dp_guard[k]    = dp_guard[k+1] | sh.dp[k];
    end

    for (int k = 1; k < 4; k++) begin
      blank_pos[k] = (LZ_BLANK != 0) && (sh.dig[k] == CODE_ZERO) &&
                     clear_above[k] && !dp_guard[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and decode for the active position.
  // ---------------------------------------------------------------------------
  logic [3:0] disp_code;
  logic [6:0] disp_pat;
  logic       anode_on;

  always_comb begin
    disp_code = sh.dig[scan_idx];
    if (blank_pos[scan_idx]) begin
      disp_code = CODE_BLANK;
    end
  end

  seg7_decode u_decode (
    .code (disp_code),
    .pat  (disp_pat)
  );

  // Count 0 of every slot is a dead gap: the previous anode has been released
  // and the next one is not yet driven, which removes ghosting while the
  // segment lines change. Segments and dp are parked off in the gap as well.
  assign anode_on = (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= anode_on ? an_select(scan_idx) : AN_OFF;
      seg <= anode_on ? disp_pat : SEG_BLANK;
      dp  <= ~(anode_on & sh.dp[scan_idx]);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with a behavioural display model.
// Latency: model predicts outputs one clock after the state they reflect.
// Backpressure: n/a.
module tb_seg7_scan;

  localparam int DIV = 4;
  localparam int LZ  = 1;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] dig1000, dig100, dig10, dig1;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release, captured digits (index 0 = units)
  // and captured decimal points.
  int t;
  int sh_dig[4];
  bit sh_dp[4];

  seg7_scan #(
    .REFRESH_DIV (DIV),
    .LZ_BLANK    (LZ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .dig1000 (dig1000),
    .dig100  (dig100),
    .dig10   (dig10),
    .dig1    (dig1),
    .dp_mask (dp_mask),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph table written from the display description.
  function automatic logic [6:0] glyph(input int code);
    case (code)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0111111;
      15: return 7'b1111111;
      default: return 7'b0000110;
    endcase
  endfunction

  // A position is hidden when it is a zero with nothing but zeros/blanks
  // above it and no decimal point at or above it. Units always show.
  function automatic bit hidden(input int p);
    if (LZ == 0 || p == 0) return 1'b0;
    if (sh_dig[p] != 0) return 1'b0;
    for (int j = 3; j >= p; j--) if (sh_dp[j]) return 1'b0;
    for (int j = 3; j > p; j--) if (sh_dig[j] != 0 && sh_dig[j] != 15) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d: observed %b expected %b", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 4; i++) begin
      sh_dig[i] = 15;
      sh_dp[i]  = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, predict, check at the next falling edge.
  // d = {thousands, hundreds, tens, units}.
  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] m);
    int         c, pos;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    load = ld;
    if (ld) begin
      {dig1000, dig100, dig10, dig1} = d;
      dp_mask = m;
    end else begin
      {dig1000, dig100, dig10, dig1} = 16'($urandom);
      dp_mask = 4'($urandom);
    end
    @(posedge clk);
    c   = t % DIV;
    pos = (t / DIV) % 4;
    if (c == 0) begin
      e_an  = 4'b1111;
      e_seg = 7'b1111111;
      e_dp  = 1'b1;
    end else begin
      e_an  = 4'b1111 & ~(4'b0001 << pos);
      e_seg = hidden(pos) ? 7'b1111111 : glyph(sh_dig[pos]);
      e_dp  = !sh_dp[pos];
    end
    if (ld) begin
      sh_dig[3] = int'(d[15:12]);
      sh_dig[2] = int'(d[11:8]);
      sh_dig[1] = int'(d[7:4]);
      sh_dig[0] = int'(d[3:0]);
      for (int i = 0; i < 4; i++) sh_dp[i] = m[i];
    end
    t++;
    @(negedge clk);
    chk("an", {3'b000, an}, {3'b000, e_an});
    chk("busy", {6'd0, busy}, {6'd0, ld});
    chk("dp", {6'd0, dp}, {6'd0, e_dp});
    if (e_an != 4'b1111) chk("seg", seg, e_seg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
  endtask

  task automatic check_off(input string tag);
    chk({tag, "_an"},   {3'b000, an}, 7'b0001111);
    chk({tag, "_seg"},  seg, 7'b1111111);
    chk({tag, "_dp"},   {6'd0, dp}, 7'd1);
    chk({tag, "_busy"}, {6'd0, busy}, 7'd0);
  endtask

  initial begin
    rst = 1'b0;
    load = 1'b1;  // a load during reset must be discarded
    {dig1000, dig100, dig10, dig1} = 16'h1234;
    dp_mask = 4'hF;
    model_reset();

    // Reset held for three clocks, outputs off throughout.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_off("reset");
    end
    rst = 1'b1;

    // Start-up: blank display, first anode at the second edge.
    idle(8);

    // Plain scan of 1,2,3,4.
    step(1'b1, 16'h1234, 4'h0);
    idle(16);

    // Leading-zero blanking.
    step(1'b1, 16'h0007, 4'h0);
    idle(16);
    step(1'b1, 16'h0000, 4'h0);
    idle(16);

    // Decimal point protects the zeros from hundreds down.
    step(1'b1, 16'h0005, 4'b0100);
    idle(16);

    // Special codes: minus, E, blank, 9.
    step(1'b1, 16'hABF9, 4'h0);
    idle(16);

    // Load on the terminal count: new value appears in the next slot.
    while (t % DIV != DIV - 1) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h8642, 4'b0001);
    idle(12);

    // Asynchronous reset in the middle of a lit slot.
    while (t % DIV != 2) step(1'b0, 16'h0, 4'h0);
    step(1'b1, 16'h5555, 4'hF);  // leaves busy high and a digit lit
    #2 rst = 1'b0;
    #1 check_off("async_rst");
    @(negedge clk);
    check_off("async_hold");
    rst = 1'b1;
    model_reset();
    idle(10);

    // Randomised loads against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      logic [3:0]  m;
      bit          ld;
      d  = 16'($urandom);
      // Bias digits towards zero so blanking paths get plenty of traffic.
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 2) == 0) d[k*4 +: 4] = 4'h0;
      end
      m  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      ld = ($urandom_range(0, 9) == 0);
      step(ld, d, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
